// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: instruction-sequencing FSM plus ALU and immediate decoders.
// Enables and selects are decoded from the current state; write enables are masked during reset.
module mc_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State,
    output logic       Illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b00;
        case (state)
            S_FETCH: begin
                state_next = S_DECODE;
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
            end
            S_MEMREAD: begin
                state_next = S_MEMWB;
                AdrSrc     = 1'b1;
            end
            S_MEMWB: begin
                state_next = S_FETCH;
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
            end
            S_MEMWRITE: begin
                state_next = S_FETCH;
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
            end
            S_EXECR: begin
                state_next = S_ALUWB;
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
            end
            S_EXECI: begin
                state_next = S_ALUWB;
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
            end
            S_ALUWB: begin
                state_next = S_FETCH;
                RegWrite   = 1'b1;
            end
            S_BEQ: begin
                state_next = S_FETCH;
                ALUSrcA    = 2'b10;
                alu_op     = 2'b01;
                PCWrite    = zero;
            end
            S_JAL: begin
                state_next = S_ALUWB;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCWrite    = 1'b1;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
        // Architectural writes must not fire while reset is held.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign State   = state;
    assign Illegal = (state == S_HALT);

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes expected per-cycle outputs, a negedge monitor compares.
// A second instance with HALT_ON_ILLEGAL=0 shares the inputs and is checked on its state trace.
module tb_mc_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, irw, rw, mw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        logic       ill;
    } out_t;

    typedef struct packed {
        out_t       o;
        logic       chk_skip;
        logic [3:0] st_skip;
    } entry_t;

    typedef int iq_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    logic       s_PCWrite, s_AdrSrc, s_IRWrite, s_RegWrite, s_MemWrite, s_Illegal;
    logic [1:0] s_ResultSrc, s_ALUSrcA, s_ALUSrcB, s_ImmSrc;
    logic [2:0] s_ALUControl;
    logic [3:0] s_State;

    entry_t q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .State(State), .Illegal(Illegal)
    );

    mc_controller #(.HALT_ON_ILLEGAL(1'b0)) dut_skip (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(s_PCWrite), .AdrSrc(s_AdrSrc), .IRWrite(s_IRWrite), .RegWrite(s_RegWrite),
        .MemWrite(s_MemWrite), .ResultSrc(s_ResultSrc), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB),
        .ImmSrc(s_ImmSrc), .ALUControl(s_ALUControl), .State(s_State), .Illegal(s_Illegal)
    );

    function automatic logic is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // State walk of one instruction, FETCH through its last state.
    function automatic iq_t seq_for(input logic [6:0] o);
        case (o)
            7'b0000011: return '{0, 1, 2, 3, 4};
            7'b0100011: return '{0, 1, 2, 5};
            7'b0110011: return '{0, 1, 6, 8};
            7'b0010011: return '{0, 1, 7, 8};
            7'b1100011: return '{0, 1, 9};
            default:    return '{0, 1, 10, 8};
        endcase
    endfunction

    // ALU function requested by an R/I-type arithmetic instruction.
    function automatic logic [2:0] alu_fn(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic out_t model(input int s, input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic z, input logic rst);
        out_t e = '0;
        e.st = 4'(s);
        case (o)
            7'b0100011: e.imm = 2'b01;
            7'b1100011: e.imm = 2'b10;
            7'b1101111: e.imm = 2'b11;
            default:    e.imm = 2'b00;
        endcase
        case (s)
            0:  begin e.irw = 1; e.sb = 2'b10; e.rs = 2'b10; e.pcw = 1; end
            1:  begin e.sa = 2'b01; e.sb = 2'b01; end
            2:  begin e.sa = 2'b10; e.sb = 2'b01; end
            3:  e.adr = 1;
            4:  begin e.rs = 2'b01; e.rw = 1; end
            5:  begin e.adr = 1; e.mw = 1; end
            6:  begin e.sa = 2'b10; e.alu = alu_fn(o, f3, f7); end
            7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu_fn(o, f3, f7); end
            8:  e.rw = 1;
            9:  begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
            10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
            11: e.ill = 1;
            default: ;
        endcase
        if (rst) begin
            e.pcw = 0; e.irw = 0; e.rw = 0; e.mw = 0;
        end
        return e;
    endfunction

    task automatic push(input out_t o, input logic chk_skip, input int st_skip);
        entry_t en;
        en.o        = o;
        en.chk_skip = chk_skip;
        en.st_skip  = 4'(st_skip);
        q.push_back(en);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction; abort_at >= 0 asserts reset in that cycle of the walk.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int abort_at);
        iq_t sq = seq_for(o);
        logic done = 1'b0;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int i = 0; i < sq.size() && !done; i++) begin
            if (i == abort_at) reset = 1'b1;
            push(model(sq[i], o, f3, f7, z, reset), 1'b1, sq[i]);
            step();
            if (reset) begin
                reset = 1'b0;
                done  = 1'b1;
            end
        end
    endtask

    // Illegal opcode: halting instance parks, skipping instance alternates FETCH/DECODE.
    task automatic run_illegal(input logic [6:0] o, input int hold);
        int s;
        op = o; funct3 = 3'($urandom); funct7b5 = 1'($urandom); zero = 1'($urandom);
        for (int i = 0; i < hold + 2; i++) begin
            s = (i < 2) ? i : 11;
            push(model(s, o, funct3, funct7b5, zero, 1'b0), 1'b1, i % 2);
            step();
        end
        reset = 1'b1;
        push(model(11, o, funct3, funct7b5, zero, 1'b1), 1'b1, (hold + 2) % 2);
        step();
        reset = 1'b0;
    endtask

    // Monitor: compare each scoreboard entry against the DUT away from the clock edge.
    initial begin
        entry_t e;
        out_t   a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a.st = State;   a.pcw = PCWrite; a.adr = AdrSrc; a.irw = IRWrite;
                a.rw = RegWrite; a.mw = MemWrite; a.rs = ResultSrc; a.sa = ALUSrcA;
                a.sb = ALUSrcB; a.imm = ImmSrc; a.alu = ALUControl; a.ill = Illegal;
                total++;
                if (a !== e.o) begin
                    bad++;
                    $display("FAIL outputs t=%0t st=%0d: got %h want %h", $time, e.o.st, a, e.o);
                end
                if (e.chk_skip) begin
                    total++;
                    if ({s_State, s_Illegal} !== {e.st_skip, 1'b0}) begin
                        bad++;
                        $display("FAIL skip_state t=%0t: got st=%0d ill=%0b want st=%0d ill=0",
                                 $time, s_State, s_Illegal, e.st_skip);
                    end
                end
            end
        end
    end

    initial begin
        logic [6:0] o;
        int         k, ab;
        iq_t        sq;
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        step();
        push(model(0, op, funct3, funct7b5, zero, 1'b1), 1'b1, 0);
        step();
        reset = 1'b0;

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, -1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, -1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, -1);
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, -1);
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, -1);
        run_illegal(7'b0000000, 10);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3);
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, -1);

        for (int n = 0; n < 150; n++) begin
            k = int'($urandom_range(0, 13));
            if (k == 13) begin
                do o = 7'($urandom); while (is_legal(o));
                run_illegal(o, int'($urandom_range(1, 4)));
            end else begin
                case (k % 6)
                    0: o = 7'b0000011;
                    1: o = 7'b0100011;
                    2: o = 7'b0110011;
                    3: o = 7'b0010011;
                    4: o = 7'b1100011;
                    default: o = 7'b1101111;
                endcase
                sq = seq_for(o);
                ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, sq.size() - 1)) : -1;
                run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), ab);
            end
        end

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
